mux16_rr_arbiter: RTL and testbench
===================================

// Module: mux16_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one mux16 (16:1 bit mux) among 16 requesters.
//  Picks one active requester and drives the mux select with its index.
//  Holds the grant for a bounded number of cycles, then rotates priority.
//  Sits in front of mux16 (instantiated internally); q carries the granted channel's bit.
// PARAMETERS
//  MAX_HOLD  4  max consecutive cycles one grant is held (1..16; 1 = rotate every cycle)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req        in   16  request vector, bit i = requester i wants the mux
//  done       in   1   current owner releases early (sampled only while gnt_valid)
//  in         in   16  data bits to mux16, bit i belongs to requester i
//  gnt        out  16  one-hot grant (registered)
//  gnt_valid  out  1   a grant is active (registered)
//  sel        out  4   index of granted requester, drives mux16 sel (registered)
//  q          out  1   mux16 output: in[sel] when gnt_valid, else 0
// BEHAVIOUR
//  Reset (rst_n=0, async): gnt=0, gnt_valid=0, sel=0, hold_cnt=0, last_ptr=15, state=IDLE.
//  q is combinational from sel/in/gnt_valid; reset forces q=0.
//  Search order: last_ptr+1, last_ptr+2, ... wrap mod 16; first set req bit wins.
//  FSM IDLE:
//   - |req=0: stay IDLE, outputs hold reset values (sel keeps last value, gnt=0).
//   - |req=1: next edge -> GRANT, gnt=onehot(winner), sel=winner, gnt_valid=1, hold_cnt=0.
//   - Latency req->gnt: 1 clock.
//  FSM GRANT, release when any of (same cycle, single release):
//   - req[sel]==0, or done==1, or hold_cnt==MAX_HOLD-1.
//   - No release: hold_cnt+1, gnt/sel unchanged.
//   - On release: last_ptr<=sel; re-arbitrate on current req with search starting at sel+1
//     (current owner lowest priority, still eligible if its req is high and release was not req drop).
//   - Winner exists: back-to-back grant next edge, no idle bubble, hold_cnt=0.
//   - No winner: next edge -> IDLE, gnt=0, gnt_valid=0.
//  Single requester continuously asserting: re-granted to itself every MAX_HOLD cycles, gnt never drops.
//  Simultaneous req drop + done + timeout: treated as one release.
//  req bits other than the owner's changing mid-grant: no effect until release.
//  Reset mid-grant: outputs clear immediately (async); after release, first search starts at 0.
//  hold_cnt width: 4 bits; never exceeds MAX_HOLD-1.
// TESTING
//  1 rst_n=0 with req=16'hFFFF, in=16'hFFFF -> gnt=0, gnt_valid=0, sel=0, q=0.
//  2 release reset, req=16'h0020 held, in=16'h0020 -> 1 clk later gnt=16'h0020, sel=5, q=1;
//    gnt stays 0x0020 continuously across timeout boundaries (cycles 4, 8, ...).
//  3 req=16'hFFFF, MAX_HOLD=4 -> sel=0,1,2,...,15,0 each held exactly 4 cycles, one-hot gnt.
//  4 req=16'h1008, grant on 3; drop req[3] after 2 cycles -> next edge sel=12, gnt=16'h1000.
//  5 last_ptr=15 (after owner 15 releases), req=16'h4001 -> sel=0 first, then sel=14.
//  6 during grant to 7, pulse rst_n low mid-cycle -> gnt=0, q=0 immediately;
//    after release with req=16'h0081 -> sel=0 granted first.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
//   Round-robin arbiter that shares one 16:1 bit mux among 16 requesters.
//   The winning requester's index drives the mux select; a grant is held for
//   at most MAX_HOLD cycles before priority rotates past the current owner.
//
// Parameters
//   MAX_HOLD   max consecutive cycles one grant is held (1..16)
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req        in   16  request vector, bit i = requester i wants the mux
//   done       in   1   current owner releases early (only looked at while granted)
//   in         in   16  data bits to the mux, bit i belongs to requester i
//   gnt        out  16  one-hot grant (registered)
//   gnt_valid  out  1   a grant is active (registered)
//   sel        out  4   index of granted requester / mux select (registered)
//   q          out  1   in[sel] while gnt_valid, else 0

module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  input  logic [15:0] in,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic [3:0]  sel,
  output logic        q
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  // First set request bit at or after 'start', wrapping mod 16.
  // Returns {found, index}. Scans from the far end so the nearest hit
  // overwrites any farther one.
  function automatic logic [4:0] find_winner(input logic [15:0] r, input logic [3:0] start);
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'b0_0000;
    for (int k = 15; k >= 0; k--) begin
      idx = start + 4'(k);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // The 16:1 bit mux that this arbiter fronts.
  function automatic logic mux16(input logic [15:0] d, input logic [3:0] s);
    return d[s];
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] gnt_r, gnt_nxt_s;
  logic        gnt_valid_r, gnt_valid_nxt_s;
  logic [3:0]  sel_r, sel_nxt_s;
  logic [3:0]  hold_cnt_r, hold_cnt_nxt_s;
  logic [3:0]  last_ptr_r, last_ptr_nxt_s;

  logic        release_s;
  logic [3:0]  search_start_s;
  logic [4:0]  winner_s;

  // Release detection and arbitration search. While granted the search
  // starts just past the owner, making it lowest priority but still
  // eligible if it keeps requesting.
  always_comb begin
    if (state_r == GRANT) begin
      search_start_s = sel_r + 4'd1;
      release_s      = (req[sel_r] == 1'b0) || done || (hold_cnt_r == HOLD_LAST);
    end else begin
      search_start_s = last_ptr_r + 4'd1;
      release_s      = 1'b0;
    end
    winner_s = find_winner(req, search_start_s);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (winner_s[4]) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s && !winner_s[4]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and arbitration bookkeeping.
  // sel is left untouched when dropping back to idle.
  always_comb begin
    gnt_nxt_s       = gnt_r;
    gnt_valid_nxt_s = gnt_valid_r;
    sel_nxt_s       = sel_r;
    hold_cnt_nxt_s  = hold_cnt_r;
    last_ptr_nxt_s  = last_ptr_r;
    case (state_r)
      IDLE: begin
        if (winner_s[4]) begin
          gnt_nxt_s       = 16'h0001 << winner_s[3:0];
          gnt_valid_nxt_s = 1'b1;
          sel_nxt_s       = winner_s[3:0];
          hold_cnt_nxt_s  = 4'd0;
        end else begin
          gnt_nxt_s       = 16'h0000;
          gnt_valid_nxt_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          last_ptr_nxt_s = sel_r;
          if (winner_s[4]) begin
            gnt_nxt_s       = 16'h0001 << winner_s[3:0];
            gnt_valid_nxt_s = 1'b1;
            sel_nxt_s       = winner_s[3:0];
            hold_cnt_nxt_s  = 4'd0;
          end else begin
            gnt_nxt_s       = 16'h0000;
            gnt_valid_nxt_s = 1'b0;
            hold_cnt_nxt_s  = 4'd0;
          end
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + 4'd1;
        end
      end
      default: begin
        gnt_nxt_s       = 16'h0000;
        gnt_valid_nxt_s = 1'b0;
        hold_cnt_nxt_s  = 4'd0;
      end
    endcase
  end

  // Output and bookkeeping registers. last_ptr resets to 15 so the first
  // search after reset begins at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r       <= 16'h0000;
      gnt_valid_r <= 1'b0;
      sel_r       <= 4'd0;
      hold_cnt_r  <= 4'd0;
      last_ptr_r  <= 4'd15;
    end else begin
      gnt_r       <= gnt_nxt_s;
      gnt_valid_r <= gnt_valid_nxt_s;
      sel_r       <= sel_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      last_ptr_r  <= last_ptr_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign sel       = sel_r;
  assign q         = gnt_valid_r & mux16(in, sel_r);

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus a
// randomized run, all compared against a behavioural round-robin model.

module tb_mux16_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk_s = 1'b0;
  logic        rst_n_s;
  logic [15:0] req_s;
  logic        done_s;
  logic [15:0] in_s;
  logic [15:0] gnt_s;
  logic        gnt_valid_s;
  logic [3:0]  sel_s;
  logic        q_s;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state: who owns the mux, for how long, who owned last.
  int m_valid;
  int m_sel;
  int m_hold;
  int m_last;

  mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk_s),
    .rst_n     (rst_n_s),
    .req       (req_s),
    .done      (done_s),
    .in        (in_s),
    .gnt       (gnt_s),
    .gnt_valid (gnt_valid_s),
    .sel       (sel_s),
    .q         (q_s)
  );

  // Free-running clock.
  always #5 clk_s = ~clk_s;

  function automatic int pick(input logic [15:0] r, input int from);
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = (from + k) % 16;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_gnt();
    return (m_valid != 0) ? (16'h0001 << m_sel) : 16'h0000;
  endfunction

  function automatic logic exp_q();
    return (m_valid != 0) ? in_s[m_sel] : 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sel = 0; m_hold = 0; m_last = 15;
  endtask

  // One clock of arbitration, expressed directly in round-robin terms.
  task automatic model_step(input logic [15:0] r, input logic d);
    int w;
    if (m_valid == 0) begin
      w = pick(r, (m_last + 1) % 16);
      if (w >= 0) begin m_valid = 1; m_sel = w; m_hold = 0; end
    end else if (!r[m_sel] || d || m_hold == MAX_HOLD - 1) begin
      m_last = m_sel;
      w = pick(r, (m_sel + 1) % 16);
      if (w >= 0) begin m_sel = w; m_hold = 0; end
      else begin m_valid = 0; m_hold = 0; end
    end else begin
      m_hold = m_hold + 1;
    end
  endtask

  // Advance model and DUT by one clock, then settle past the edge.
  task automatic tick();
    model_step(req_s, done_s);
    @(posedge clk_s);
    #1;
  endtask

  task automatic do_reset();
    rst_n_s = 1'b0;
    @(posedge clk_s);
    #1;
    rst_n_s = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n_s = 1'b0; req_s = 16'hFFFF; in_s = 16'hFFFF; done_s = 1'b0;
    @(posedge clk_s);
    #1;
    n_cmp++; if (gnt_s !== 16'h0000) begin n_err++; $display("FAIL reset_gnt got=%h want=0000", gnt_s); end
    n_cmp++; if (gnt_valid_s !== 1'b0) begin n_err++; $display("FAIL reset_gnt_valid got=%b want=0", gnt_valid_s); end
    n_cmp++; if (sel_s !== 4'd0) begin n_err++; $display("FAIL reset_sel got=%0d want=0", sel_s); end
    n_cmp++; if (q_s !== 1'b0) begin n_err++; $display("FAIL reset_q got=%b want=0", q_s); end
    model_reset();
  endtask

  task automatic test_single_requester();
    rst_n_s = 1'b1; req_s = 16'h0020; in_s = 16'h0020; done_s = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      n_cmp++;
      if ({gnt_s, gnt_valid_s, sel_s, q_s} !== {16'h0020, 1'b1, 4'd5, 1'b1}) begin
        n_err++;
        $display("FAIL single cyc=%0d got gnt=%h v=%b sel=%0d q=%b want gnt=0020 v=1 sel=5 q=1",
                 c, gnt_s, gnt_valid_s, sel_s, q_s);
      end
    end
  endtask

  task automatic test_all_requesters();
    do_reset();
    req_s = 16'hFFFF; done_s = 1'b0;
    for (int c = 0; c < 16 * MAX_HOLD + 4; c++) begin
      in_s = 16'($urandom);
      tick();
      n_cmp++;
      if ({gnt_s, gnt_valid_s, sel_s} !== {16'h0001 << ((c / MAX_HOLD) % 16), 1'b1, 4'((c / MAX_HOLD) % 16)}) begin
        n_err++;
        $display("FAIL rotate cyc=%0d got gnt=%h v=%b sel=%0d want sel=%0d",
                 c, gnt_s, gnt_valid_s, sel_s, (c / MAX_HOLD) % 16);
      end
      n_cmp++;
      if (q_s !== exp_q()) begin
        n_err++; $display("FAIL rotate_q cyc=%0d got=%b want=%b", c, q_s, exp_q());
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req_s = 16'h1008; done_s = 1'b0; in_s = 16'h1008;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({gnt_s, sel_s} !== {16'h0008, 4'd3}) begin
        n_err++; $display("FAIL drop_own cyc=%0d got gnt=%h sel=%0d want gnt=0008 sel=3", c, gnt_s, sel_s);
      end
    end
    req_s = 16'h1000;
    tick();
    n_cmp++;
    if ({gnt_s, gnt_valid_s, sel_s, q_s} !== {16'h1000, 1'b1, 4'd12, 1'b1}) begin
      n_err++;
      $display("FAIL drop_next got gnt=%h v=%b sel=%0d q=%b want gnt=1000 v=1 sel=12 q=1",
               gnt_s, gnt_valid_s, sel_s, q_s);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_s = 16'h8000; done_s = 1'b0; in_s = 16'($urandom);
    tick();
    n_cmp++;
    if (sel_s !== 4'd15) begin n_err++; $display("FAIL wrap_own15 got=%0d want=15", sel_s); end
    req_s = 16'h4001;
    tick();
    n_cmp++;
    if ({gnt_s, sel_s} !== {16'h0001, 4'd0}) begin
      n_err++; $display("FAIL wrap_first got gnt=%h sel=%0d want gnt=0001 sel=0", gnt_s, sel_s);
    end
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      tick();
      n_cmp++;
      if ({gnt_s, gnt_valid_s, sel_s, q_s} !== {exp_gnt(), 1'(m_valid), 4'(m_sel), exp_q()}) begin
        n_err++; $display("FAIL wrap_hold cyc=%0d got gnt=%h sel=%0d want gnt=%h", c, gnt_s, sel_s, exp_gnt());
      end
    end
    tick();
    n_cmp++;
    if ({gnt_s, sel_s} !== {16'h4000, 4'd14}) begin
      n_err++; $display("FAIL wrap_second got gnt=%h sel=%0d want gnt=4000 sel=14", gnt_s, sel_s);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_s = 16'h0080; done_s = 1'b0; in_s = 16'($urandom) | 16'h0080;
    tick();
    tick();
    n_cmp++;
    if ({gnt_s, sel_s, q_s} !== {16'h0080, 4'd7, 1'b1}) begin
      n_err++; $display("FAIL midrst_pre got gnt=%h sel=%0d q=%b want gnt=0080 sel=7 q=1", gnt_s, sel_s, q_s);
    end
    @(negedge clk_s);
    rst_n_s = 1'b0;
    #1;
    n_cmp++;
    if ({gnt_s, gnt_valid_s, q_s} !== {16'h0000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL midrst_clear got gnt=%h v=%b q=%b want gnt=0000 v=0 q=0", gnt_s, gnt_valid_s, q_s);
    end
    @(posedge clk_s);
    #1;
    rst_n_s = 1'b1;
    model_reset();
    req_s = 16'h0081;
    tick();
    n_cmp++;
    if ({gnt_s, gnt_valid_s, sel_s} !== {16'h0001, 1'b1, 4'd0}) begin
      n_err++; $display("FAIL midrst_after got gnt=%h v=%b sel=%0d want gnt=0001 v=1 sel=0", gnt_s, gnt_valid_s, sel_s);
    end
  endtask

  task automatic test_random();
    do_reset();
    req_s = 16'h0000; done_s = 1'b0;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: req_s = 16'($urandom);
        1: req_s = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: req_s = (c % 50 < 5) ? 16'h0000 : req_s;
        default: req_s = req_s;
      endcase
      done_s = ($urandom_range(0, 4) == 0);
      in_s   = 16'($urandom);
      tick();
      n_cmp++;
      if ({gnt_s, gnt_valid_s, sel_s, q_s} !== {exp_gnt(), 1'(m_valid), 4'(m_sel), exp_q()}) begin
        n_err++;
        $display("FAIL random cyc=%0d got gnt=%h v=%b sel=%0d q=%b want gnt=%h v=%0d sel=%0d q=%b",
                 c, gnt_s, gnt_valid_s, sel_s, q_s, exp_gnt(), m_valid, m_sel, exp_q());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_requester();
    test_all_requesters();
    test_req_drop();
    test_wrap();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
